// File: rtl/dds_channel_scheduler_pkg.sv
// Shared defaults and the tag record for the DDS channel scheduler.
package dds_sched_pkg;

  localparam int DEF_DATA_WIDTH   = 16;
  localparam int DEF_PHASE_WIDTH  = 24;
  localparam int DEF_NUM_CH       = 4;
  localparam int DEF_EVAL_LATENCY = 3;

  // Channel index width carried in each tag; the scheduler's NUM_CH must match DEF_NUM_CH.
  localparam int TAG_CH_W = $clog2(DEF_NUM_CH);

  // One in-flight evaluator request: which channel it belongs to and whether it is real.
  typedef struct packed {
    logic                valid;
    logic [TAG_CH_W-1:0] ch;
  } tag_t;

endpackage

// File: rtl/dds_channel_scheduler_tag_pipe.sv
// Tag delay line that travels alongside the shared evaluator pipeline.
module dds_tag_pipe
  import dds_sched_pkg::*;
#(
  parameter int DEPTH = DEF_EVAL_LATENCY
) (
  input  logic clk,
  input  logic rst,
  input  logic shift,
  input  tag_t tag_in,
  output tag_t tag_out,
  output logic any_valid
);

  tag_t stage_r [DEPTH];
  logic any_valid_s;

  // Shift tags one stage per evaluator advance; reset discards everything in flight.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_r[i] <= '0;
      end
    end else if (shift) begin
      stage_r[0] <= tag_in;
      for (int i = 1; i < DEPTH; i++) begin
        stage_r[i] <= stage_r[i-1];
      end
    end
  end

  // Any valid stage means a result is still owed.
  always_comb begin
    any_valid_s = 1'b0;
    for (int i = 0; i < DEPTH; i++) begin
      any_valid_s = any_valid_s | stage_r[i].valid;
    end
  end

  assign tag_out   = stage_r[DEPTH-1];
  assign any_valid = any_valid_s;

endmodule

// File: rtl/dds_channel_scheduler.sv
// Time-multiplexes NUM_CH phase accumulators onto one shared polynomial evaluator
// and tags each returned result with its channel.
module dds_channel_scheduler
  import dds_sched_pkg::*;
#(
  parameter int DATA_WIDTH   = DEF_DATA_WIDTH,
  parameter int PHASE_WIDTH  = DEF_PHASE_WIDTH,
  parameter int NUM_CH       = DEF_NUM_CH,
  parameter int EVAL_LATENCY = DEF_EVAL_LATENCY
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       enable,
  input  logic                       cfg_we,
  input  logic                       cfg_clr,
  input  logic [$clog2(NUM_CH)-1:0]  cfg_ch,
  input  logic [PHASE_WIDTH-1:0]     cfg_fcw,
  output logic [DATA_WIDTH-1:0]      eval_x,
  output logic                       eval_enable,
  input  logic [DATA_WIDTH-1:0]      eval_result,
  output logic [DATA_WIDTH-1:0]      ch_out,
  output logic [$clog2(NUM_CH)-1:0]  ch_id,
  output logic                       ch_valid,
  output logic                       busy
);

  localparam int CH_W = $clog2(NUM_CH);

  logic [CH_W-1:0]        slot_r;
  logic [PHASE_WIDTH-1:0] acc_r [NUM_CH];
  logic [PHASE_WIDTH-1:0] fcw_r [NUM_CH];
  logic [DATA_WIDTH-1:0]  eval_x_r;
  logic [DATA_WIDTH-1:0]  ch_out_r;
  logic [CH_W-1:0]        ch_id_r;
  logic                   ch_valid_r;
  tag_t                   tag_in_s;
  tag_t                   tag_last_s;
  logic                   busy_s;
  logic                   eval_enable_s;

  // The evaluator advances while issuing or while results are still owed; held idle in reset.
  assign eval_enable_s = (enable & rst) | busy_s;

  // Round-robin slot and the registered evaluator argument (pre-update phase, top bits).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      slot_r   <= '0;
      eval_x_r <= '0;
    end else if (enable) begin
      slot_r   <= slot_r + CH_W'(1);
      eval_x_r <= acc_r[slot_r][PHASE_WIDTH-1 -: DATA_WIDTH];
    end
  end

  // Phase accumulators: a clear of the issuing channel overrides its increment.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        acc_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (cfg_clr && (cfg_ch == CH_W'(k))) begin
          acc_r[k] <= '0;
        end else if (enable && (slot_r == CH_W'(k))) begin
          acc_r[k] <= acc_r[k] + fcw_r[k];
        end
      end
    end
  end

  // Frequency control words; the issue in the same cycle still sees the old word.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < NUM_CH; k++) begin
        fcw_r[k] <= '0;
      end
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (cfg_we && (cfg_ch == CH_W'(k))) begin
          fcw_r[k] <= cfg_fcw;
        end
      end
    end
  end

  // New tag for the issue happening this cycle, or an empty bubble.
  always_comb begin
    tag_in_s = '0;
    if (enable) begin
      tag_in_s.valid = 1'b1;
      tag_in_s.ch    = slot_r;
    end else begin
      tag_in_s.valid = 1'b0;
      tag_in_s.ch    = '0;
    end
  end

  dds_tag_pipe #(
    .DEPTH (EVAL_LATENCY)
  ) u_tag_pipe (
    .clk       (clk),
    .rst       (rst),
    .shift     (eval_enable_s),
    .tag_in    (tag_in_s),
    .tag_out   (tag_last_s),
    .any_valid (busy_s)
  );

  // Capture the evaluator result when its tag reaches the end; outputs hold otherwise.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ch_out_r   <= '0;
      ch_id_r    <= '0;
      ch_valid_r <= 1'b0;
    end else if (tag_last_s.valid && eval_enable_s) begin
      ch_out_r   <= eval_result;
      ch_id_r    <= tag_last_s.ch;
      ch_valid_r <= 1'b1;
    end else begin
      ch_valid_r <= 1'b0;
    end
  end

  assign eval_x      = eval_x_r;
  assign eval_enable = eval_enable_s;
  assign ch_out      = ch_out_r;
  assign ch_id       = ch_id_r;
  assign ch_valid    = ch_valid_r;
  assign busy        = busy_s;

endmodule

// File: tb/tb_dds_channel_scheduler.sv
// Self-checking bench: history-based reference model plus directed literal checks.
module tb_dds_channel_scheduler;

  localparam int LAT  = 3;
  localparam int MAXE = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        cfg_we;
  logic        cfg_clr;
  logic [1:0]  cfg_ch;
  logic [23:0] cfg_fcw;
  logic [15:0] eval_x;
  logic        eval_enable;
  logic [15:0] eval_result;
  logic [15:0] ch_out;
  logic [1:0]  ch_id;
  logic        ch_valid;
  logic        busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  dds_channel_scheduler dut (
    .clk         (clk),
    .rst         (rst),
    .enable      (enable),
    .cfg_we      (cfg_we),
    .cfg_clr     (cfg_clr),
    .cfg_ch      (cfg_ch),
    .cfg_fcw     (cfg_fcw),
    .eval_x      (eval_x),
    .eval_enable (eval_enable),
    .eval_result (eval_result),
    .ch_out      (ch_out),
    .ch_id       (ch_id),
    .ch_valid    (ch_valid),
    .busy        (busy)
  );

  // Evaluator stand-in: identity function with LAT cycles from issue to captured result.
  logic [15:0] ev_d0 = 16'h0000;
  logic [15:0] ev_d1 = 16'h0000;
  always @(posedge clk) begin
    if (eval_enable) begin
      ev_d0 <= eval_x;
      ev_d1 <= ev_d0;
    end
  end
  assign eval_result = ev_d1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model (issue history per clock edge) ----------------
  int          n = 0;
  bit          issued [MAXE];
  logic [15:0] idata  [MAXE];
  logic [1:0]  ich    [MAXE];
  logic [23:0] m_acc  [4];
  logic [23:0] m_fcw  [4];
  int          m_slot = 0;
  logic [15:0] m_eval_x = 16'h0000;
  logic [15:0] m_out = 16'h0000;
  logic [1:0]  m_id = 2'd0;
  bit          m_valid = 1'b0;
  bit          m_busy = 1'b0;

  task automatic model_step();
    n++;
    if (!rst) begin
      for (int k = 0; k < 4; k++) begin
        m_acc[k] = 24'h0;
        m_fcw[k] = 24'h0;
      end
      m_slot   = 0;
      m_eval_x = 16'h0000;
      m_out    = 16'h0000;
      m_id     = 2'd0;
      m_valid  = 1'b0;
      for (int d = 0; d <= LAT; d++) begin
        if (n - d >= 0) issued[n-d] = 1'b0;
      end
    end else begin
      issued[n] = enable;
      if (enable) begin
        idata[n]  = m_acc[m_slot][23:8];
        ich[n]    = 2'(m_slot);
        m_eval_x  = idata[n];
        m_acc[m_slot] = m_acc[m_slot] + m_fcw[m_slot];
        m_slot    = (m_slot + 1) % 4;
      end
      if (cfg_clr) m_acc[cfg_ch] = 24'h0;
      if (cfg_we)  m_fcw[cfg_ch] = cfg_fcw;
      m_valid = (n >= LAT) && issued[n-LAT];
      if (m_valid) begin
        m_out = idata[n-LAT];
        m_id  = ich[n-LAT];
      end
    end
    m_busy = issued[n] || (n >= 1 && issued[n-1]) || (n >= 2 && issued[n-2]);
  endtask

  initial begin
    forever begin
      @(posedge clk);
      model_step();
    end
  end

  // Compare DUT against model every cycle, mid-period.
  initial begin
    forever begin
      @(negedge clk);
      if (!rst) begin
        chk("rst_ch_valid", 32'(ch_valid), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_eval_enable", 32'(eval_enable), 32'd0);
        chk("rst_eval_x", 32'(eval_x), 32'd0);
        chk("rst_ch_out", 32'(ch_out), 32'd0);
        chk("rst_ch_id", 32'(ch_id), 32'd0);
      end else begin
        chk("ch_valid", 32'(ch_valid), 32'(m_valid));
        chk("busy", 32'(busy), 32'(m_busy));
        chk("eval_enable", 32'(eval_enable), 32'(enable | m_busy));
        chk("eval_x", 32'(eval_x), 32'(m_eval_x));
        chk("ch_out", 32'(ch_out), 32'(m_out));
        chk("ch_id", 32'(ch_id), 32'(m_id));
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic idle();
    enable  = 1'b0;
    cfg_we  = 1'b0;
    cfg_clr = 1'b0;
    cfg_ch  = 2'd0;
    cfg_fcw = 24'h0;
  endtask

  // ---------------- stimulus ----------------
  int pulses;

  initial begin
    rst = 1'b0;
    idle();

    // Reset held while inputs toggle.
    for (int i = 0; i < 8; i++) begin
      tick();
      enable  = 1'($urandom_range(0, 1));
      cfg_we  = 1'($urandom_range(0, 1));
      cfg_clr = 1'($urandom_range(0, 1));
      cfg_ch  = 2'($urandom_range(0, 3));
      cfg_fcw = 24'($urandom);
      chk("hold_rst_ch_valid", 32'(ch_valid), 32'd0);
    end
    idle();
    tick();
    rst = 1'b1;
    tick();

    // Single active channel: ch0 steps by 0x0100 per visit, results every cycle.
    cfg_we = 1'b1; cfg_ch = 2'd0; cfg_fcw = 24'h010000;
    tick();
    cfg_we = 1'b0; enable = 1'b1;
    for (int i = 0; i <= 8; i++) begin
      tick();
      if (i == 0) chk("ch0_x0", 32'(eval_x), 32'h0000);
      if (i == 4) chk("ch0_x1", 32'(eval_x), 32'h0100);
      if (i == 8) chk("ch0_x2", 32'(eval_x), 32'h0200);
      if (i >= 3 && i <= 7) begin
        chk("seq_valid", 32'(ch_valid), 32'd1);
        chk("seq_id", 32'(ch_id), 32'((i - 3) % 4));
      end
      if (i == 2) chk("first_latency", 32'(ch_valid), 32'd0);
      if (i == 3) chk("seq_out0", 32'(ch_out), 32'h0000);
      if (i == 7) chk("seq_out4", 32'(ch_out), 32'h0100);
    end
    enable = 1'b0;
    repeat (5) tick();

    // Six issues then enable drops: six results, busy drains.
    pulses = 0;
    enable = 1'b1;
    for (int i = 0; i <= 12; i++) begin
      tick();
      if (ch_valid) pulses++;
      if (i == 7) chk("drain_busy_hi", 32'(busy), 32'd1);
      if (i == 8) begin
        chk("drain_busy_lo", 32'(busy), 32'd0);
        chk("drain_ee_lo", 32'(eval_enable), 32'd0);
      end
      if (i == 5) enable = 1'b0;
    end
    chk("drain_pulses", 32'(pulses), 32'd6);

    // Fresh reset, then wrap on ch1 and clear/write collision on ch2.
    rst = 1'b0;
    tick();
    rst = 1'b1;
    cfg_we = 1'b1; cfg_ch = 2'd1; cfg_fcw = 24'h800000;
    tick();
    cfg_ch = 2'd2; cfg_fcw = 24'h123400;
    tick();
    cfg_we = 1'b0; enable = 1'b1;
    for (int i = 0; i <= 22; i++) begin
      tick();
      case (i)
        1:  chk("wrap_x0", 32'(eval_x), 32'h0000);
        5:  chk("wrap_x1", 32'(eval_x), 32'h8000);
        9:  chk("wrap_x2", 32'(eval_x), 32'h0000);
        13: chk("wrap_x3", 32'(eval_x), 32'h8000);
        10: chk("ch2_pre", 32'(eval_x), 32'h2468);
        14: chk("ch2_preclear", 32'(eval_x), 32'h369C);
        18: chk("ch2_after_clr", 32'(eval_x), 32'h0000);
        22: chk("ch2_new_fcw", 32'(eval_x), 32'h0001);
        default: ;
      endcase
      if (i == 13) begin
        cfg_we = 1'b1; cfg_clr = 1'b1; cfg_ch = 2'd2; cfg_fcw = 24'h000100;
      end
      if (i == 14) begin
        cfg_we = 1'b0; cfg_clr = 1'b0;
      end
    end

    // Asynchronous reset with tags in flight.
    rst = 1'b0;
    #1;
    chk("async_ch_valid", 32'(ch_valid), 32'd0);
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_ee", 32'(eval_enable), 32'd0);
    tick();
    rst = 1'b1;
    for (int i = 0; i <= 3; i++) begin
      tick();
      if (i < 3) chk("no_stale", 32'(ch_valid), 32'd0);
      if (i == 3) begin
        chk("post_rst_valid", 32'(ch_valid), 32'd1);
        chk("post_rst_id", 32'(ch_id), 32'd0);
      end
    end

    // Randomized traffic against the model.
    for (int i = 0; i < 1500; i++) begin
      tick();
      enable  = ($urandom_range(0, 3) != 0);
      cfg_we  = ($urandom_range(0, 9) == 0);
      cfg_clr = ($urandom_range(0, 9) == 0);
      cfg_ch  = 2'($urandom_range(0, 3));
      cfg_fcw = 24'($urandom);
      rst     = ($urandom_range(0, 299) != 0);
    end
    idle();
    rst = 1'b1;
    repeat (6) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
